// File: rtl/refmem_access_ctrl_if.sv
// Purpose: bundles the burst-read, single-write and RAM-pin signals of the reference-position RAM controller.
// Latency: wires only, no storage.
// Backpressure: writes stall on wr_ready; burst reads are flow-controlled by rd_busy/rd_done.
// Ports (slave = controller view):
//   rd_start/rd_base_addr/rd_count in, rd_busy/rd_done/rd_data/rd_data_valid/rd_data_last out
//   wr_valid/wr_addr/wr_data in, wr_ready out
//   mem_address/mem_data/mem_rden/mem_wren out, mem_q in
interface refmem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  rd_start;
    logic [ADDR_WIDTH-1:0] rd_base_addr;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  rd_busy;
    logic                  rd_done;
    logic [31:0]           rd_data;
    logic                  rd_data_valid;
    logic                  rd_data_last;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [31:0]           mem_q;

    modport slave (
        input  rd_start, rd_base_addr, rd_count, wr_valid, wr_addr, wr_data, mem_q,
        output rd_busy, rd_done, rd_data, rd_data_valid, rd_data_last, wr_ready,
               mem_address, mem_data, mem_rden, mem_wren
    );

    modport master (
        output rd_start, rd_base_addr, rd_count, wr_valid, wr_addr, wr_data, mem_q,
        input  rd_busy, rd_done, rd_data, rd_data_valid, rd_data_last, wr_ready,
               mem_address, mem_data, mem_rden, mem_wren
    );
endinterface

// File: rtl/refmem_access_ctrl.sv
// Purpose: shares one single-port reference-position RAM between a burst reader and a single-word writer.
// Latency: grant -> mem_* pins 1 cycle; mem_rden -> rd_data_valid READ_LATENCY cycles; last valid -> rd_done 1 cycle.
// Backpressure: wr_ready drops only while issuing reads after MAX_STALL back-to-back writes; rd_start ignored while busy or on rd_done.
// Ports: clock, rst_n (async active-low) plus bus (refmem_access_ctrl_if.slave) carrying the
//        burst-read request/response, the write request/ready and the RAM address/data/rden/wren/q pins.
module refmem_access_ctrl #(
    parameter int DEPTH        = 512,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2,
    parameter int MAX_STALL    = 4
) (
    input  logic                 clock,
    input  logic                 rst_n,
    refmem_access_ctrl_if.slave  bus
);
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_LEFT  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH:0]     r_remain;
    logic [SW-1:0]           r_stall;
    logic                    r_done;
    logic                    r_mem_rden;
    logic                    r_mem_wren;
    logic                    r_mem_last;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [31:0]             r_mem_data;
    logic [READ_LATENCY-1:0] r_vld_pipe;
    logic [READ_LATENCY-1:0] r_last_pipe;

    logic w_wr_rdy;
    logic w_wr_fire;
    logic w_rd_fire;
    logic w_start_ok;
    logic w_start_zero;
    logic w_final_out;

    // Writes only lose arbitration while a burst is issuing and the stall budget is spent.
    assign w_wr_rdy    = (r_state != S_ISSUE) || (r_stall < SW'(MAX_STALL));
    assign w_wr_fire   = bus.wr_valid && w_wr_rdy;
    assign w_final_out = r_vld_pipe[READ_LATENCY-1] && r_last_pipe[READ_LATENCY-1];

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_fire    = 1'b0;
        w_start_ok   = 1'b0;
        w_start_zero = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_done high means this is the rd_done cycle: a start here is dropped.
                if (bus.rd_start && !r_done) begin
                    if (bus.rd_count == '0) begin
                        w_start_zero = 1'b1;
                    end else begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!w_wr_fire) begin
                    w_rd_fire = 1'b1;
                    if (r_remain == ONE_LEFT) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_final_out) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr   <= '0;
            r_remain    <= '0;
            r_stall     <= '0;
            r_done      <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_mem_last  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_done <= w_start_zero || ((r_state == S_DRAIN) && w_final_out);

            if (w_start_ok) begin
                r_rd_addr <= bus.rd_base_addr;
                r_remain  <= bus.rd_count;
                r_stall   <= '0;
            end else if (w_rd_fire) begin
                // Wrap at DEPTH-1 rather than at the address-width boundary.
                r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_WIDTH'(1);
                r_remain  <= r_remain - ONE_LEFT;
                r_stall   <= '0;
            end else if (w_wr_fire && (r_state == S_ISSUE)) begin
                r_stall <= r_stall + SW'(1);
            end

            r_mem_rden <= w_rd_fire;
            r_mem_wren <= w_wr_fire;
            r_mem_last <= w_rd_fire && (r_remain == ONE_LEFT);
            if (w_wr_fire) begin
                r_mem_addr <= bus.wr_addr;
                r_mem_data <= bus.wr_data;
            end else if (w_rd_fire) begin
                r_mem_addr <= r_rd_addr;
            end

            // Valid/last tags travel alongside the RAM's own read latency.
            r_vld_pipe[0]  <= r_mem_rden;
            r_last_pipe[0] <= r_mem_rden && r_mem_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    assign bus.rd_busy       = (r_state != S_IDLE);
    assign bus.rd_done       = r_done;
    assign bus.rd_data       = bus.mem_q;
    assign bus.rd_data_valid = r_vld_pipe[READ_LATENCY-1];
    assign bus.rd_data_last  = w_final_out;
    assign bus.wr_ready      = w_wr_rdy;
    assign bus.mem_address   = r_mem_addr;
    assign bus.mem_data      = r_mem_data;
    assign bus.mem_rden      = r_mem_rden;
    assign bus.mem_wren      = r_mem_wren;
endmodule
